// File: rtl/sh_store_rmw_unit.sv
// Store-halfword read-modify-write sequencer for a word-wide data RAM without byte enables.
// Reads the target word, merges the halfword into its lane, then writes the word back.
module sh_store_rmw_unit #(
    parameter int AddrBits = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ClockEnable,
    input  logic                  Tick,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AddrBits+1:0]   req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned,
    output logic [AddrBits-1:0]   mem_addr,
    output logic                  mem_rd,
    input  logic [31:0]           mem_rdata,
    output logic                  mem_wr,
    output logic [31:0]           mem_wdata
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  advance_s;
    logic                  hi_r;
    logic [15:0]           wdata_r;
    logic                  done_r;
    logic                  misaligned_r;
    logic                  mem_rd_r;
    logic                  mem_wr_r;
    logic [AddrBits-1:0]   mem_addr_r;
    logic [31:0]           mem_wdata_r;

    // Little-endian lane insert: hi selects the upper halfword.
    function automatic logic [31:0] merge_half(input logic [31:0] word,
                                               input logic [15:0] half,
                                               input logic        hi);
        merge_half = hi ? {half, word[15:0]} : {word[31:16], half};
    endfunction

    assign advance_s  = ClockEnable & Tick;
    assign req_ready  = (state_r == ST_IDLE);
    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;
    assign misaligned = misaligned_r;
    assign mem_rd     = mem_rd_r;
    assign mem_wr     = mem_wr_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

    // Next-state decode; only consulted on advance edges.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = req_addr[0] ? ST_ERR : ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ERR:  state_s = ST_IDLE;
            ST_RD:   state_s = ST_CAP;
            ST_CAP:  state_s = ST_WR;
            ST_WR:   state_s = ST_DONE;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, request latches and registered outputs; outputs decode the state being entered.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            hi_r         <= 1'b0;
            wdata_r      <= 16'h0000;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            mem_rd_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'h0000_0000;
        end else if (advance_s) begin
            state_r      <= state_s;
            done_r       <= (state_s == ST_DONE);
            misaligned_r <= (state_s == ST_ERR);
            mem_rd_r     <= (state_s == ST_RD);
            mem_wr_r     <= (state_s == ST_WR);
            if ((state_r == ST_IDLE) && req_valid) begin
                mem_addr_r <= req_addr[AddrBits+1:2];
                hi_r       <= req_addr[1];
                wdata_r    <= req_wdata;
            end
            // RAM data is valid throughout CAP; the merged word doubles as the read buffer.
            if (state_r == ST_CAP) begin
                mem_wdata_r <= merge_half(mem_rdata, wdata_r, hi_r);
            end
        end
    end

endmodule

// File: tb/tb_sh_store_rmw_unit.sv
// Self-checking bench for sh_store_rmw_unit: RAM model, table vectors, corner sequences
// and randomized stores checked against an arithmetic memory model.
module tb_sh_store_rmw_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ClockEnable = 1'b1;
    logic        Tick = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = 12'h000;
    logic [15:0] req_wdata = 16'h0000;
    logic        busy, done, misaligned, mem_rd, mem_wr;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem_wdata;

    logic [31:0] ram [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [31:0] pl_data = 32'h0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          overlap_count = 0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [0:15];

    typedef struct {
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_word;
        bit          mis;
    } vec_t;
    vec_t vecs [0:6];

    sh_store_rmw_unit #(.AddrBits(10)) dut (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .misaligned(misaligned),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata)
    );

    always #5 Clock = ~Clock;

    // Data RAM: samples strobes only on advance edges, read data registered.
    always @(posedge Clock) begin
        if (mem_rd && mem_wr) overlap_count <= overlap_count + 1;
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (ClockEnable && Tick) begin
            if (mem_rd) begin
                mem_rdata <= ram[mem_addr];
                rd_count  <= rd_count + 1;
            end
            if (mem_wr) begin
                ram[mem_addr] <= mem_wdata;
                wr_count      <= wr_count + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    // Reference store: replace one 16-bit lane using plain arithmetic.
    function automatic logic [31:0] ref_store(input logic [31:0] old, input bit hi,
                                              input logic [15:0] wd);
        int unsigned o, w;
        o = old; w = wd;
        if (hi) ref_store = (o % 32'd65536) + w * 32'd65536;
        else    ref_store = (o - (o % 32'd65536)) + w;
    endfunction

    // Issue one request from IDLE and check every advance cycle until it retires.
    task automatic do_req(input logic [11:0] addr, input logic [15:0] wd,
                          input logic [31:0] exp_word, input bit mis);
        int rd0, wr0;
        logic [9:0] w;
        w = addr[11:2];
        rd0 = rd_count; wr0 = wr_count;
        req_valid = 1'b1; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0;
        req_addr  = 12'($urandom);
        req_wdata = 16'($urandom);
        if (mis) begin
            chk("mis_pulse", {31'd0, misaligned}, 32'd1);
            chk("mis_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
            step();
            chk("mis_end", {29'd0, misaligned, done, req_ready}, 32'd1);
            chk("mis_no_access", rd_count - rd0 + wr_count - wr0, 32'd0);
        end else begin
            chk("rd_phase", {31'd0, mem_rd}, 32'd1);
            chk("rd_addr", {22'd0, mem_addr}, {22'd0, w});
            step();
            chk("cap_phase", {30'd0, mem_rd, mem_wr}, 32'd0);
            step();
            chk("wr_phase", {30'd0, mem_rd, mem_wr}, 32'd1);
            chk("wr_data", mem_wdata, exp_word);
            step();
            chk("done_pulse", {30'd0, done, mem_wr}, 32'd2);
            step();
            chk("done_end", {30'd0, done, req_ready}, 32'd1);
            chk("one_rd_one_wr", (rd_count - rd0) * 16 + (wr_count - wr0), 32'd17);
        end
        chk("ram_word", ram[w], exp_word);
    endtask

    // Abort a request by asserting Reset after n advance edges past acceptance.
    task automatic mid_reset(input logic [9:0] w, input int n);
        int wr0;
        preload(w, 32'h55AA_33CC);
        wr0 = wr_count;
        req_valid = 1'b1; req_addr = {w, 2'b00}; req_wdata = 16'h9999;
        step();
        req_valid = 1'b0;
        repeat (n) step();
        Reset = 1'b1;
        #1;
        chk("rst_idle", {29'd0, busy, req_ready, mem_wr}, 32'd2);
        chk("rst_rd", {31'd0, mem_rd}, 32'd0);
        step();
        step();
        Reset = 1'b0;
        step();
        chk("rst_no_write", wr_count - wr0, 32'd0);
        chk("rst_ram_kept", ram[w], 32'h55AA_33CC);
        do_req({w, 2'b10}, 16'h7777, 32'h7777_33CC, 1'b0);
    endtask

    initial begin
        int rd0, wr0;
        vecs[0] = '{12'h014, 16'h1234, 32'hDEADBEEF, 32'hDEAD1234, 1'b0};
        vecs[1] = '{12'h016, 16'hA5A5, 32'hDEADBEEF, 32'hA5A5BEEF, 1'b0};
        vecs[2] = '{12'h015, 16'hFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        vecs[3] = '{12'h000, 16'h0001, 32'hFFFFFFFF, 32'hFFFF0001, 1'b0};
        vecs[4] = '{12'hFFE, 16'hFFFF, 32'h11223344, 32'hFFFF3344, 1'b0};
        vecs[5] = '{12'hFFF, 16'h0BAD, 32'h11223344, 32'h11223344, 1'b1};
        vecs[6] = '{12'h017, 16'h0BAD, 32'h00000000, 32'h00000000, 1'b1};

        #12;
        chk("reset_flags", {26'd0, req_ready, busy, done, misaligned, mem_rd, mem_wr}, 32'h20);
        chk("reset_addr", {22'd0, mem_addr}, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].addr[11:2], vecs[i].init);
            do_req(vecs[i].addr, vecs[i].wdata, vecs[i].exp_word, vecs[i].mis);
        end

        // Stall: Tick low while in RD, ClockEnable low while in CAP.
        preload(10'd6, 32'h0123_4567);
        rd0 = rd_count; wr0 = wr_count;
        req_valid = 1'b1; req_addr = 12'h018; req_wdata = 16'hBEEF;
        step();
        req_valid = 1'b0;
        Tick = 1'b0;
        repeat (2) step();
        chk("stall_rd_hold", {21'd0, busy, mem_addr, mem_rd}, {21'd0, 1'b1, 10'd6, 1'b1});
        Tick = 1'b1;
        step();
        ClockEnable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_cap_hold", {20'd0, busy, mem_addr, mem_rd, mem_wr}, {20'd0, 1'b1, 10'd6, 2'b00});
        end
        ClockEnable = 1'b1;
        step();
        chk("stall_wr_data", mem_wdata, 32'h0123_BEEF);
        step();
        chk("stall_done", {31'd0, done}, 32'd1);
        step();
        chk("stall_counts", (rd_count - rd0) * 16 + (wr_count - wr0), 32'd17);
        chk("stall_ram", ram[6], 32'h0123_BEEF);

        // Back-to-back with req_valid held high.
        preload(10'd5, 32'hDEADBEEF);
        preload(10'd6, 32'hCAFEF00D);
        wr0 = wr_count;
        req_valid = 1'b1; req_addr = 12'h014; req_wdata = 16'h1111;
        step();
        req_addr = 12'h01A; req_wdata = 16'h2222;
        chk("b2b_first_addr", {22'd0, mem_addr}, 32'd5);
        repeat (2) step();
        chk("b2b_first_wdata", mem_wdata, 32'hDEAD1111);
        step();
        chk("b2b_done_not_ready", {30'd0, done, req_ready}, 32'd2);
        step();
        chk("b2b_idle_gap", {29'd0, req_ready, busy, mem_rd}, 32'd4);
        step();
        req_valid = 1'b0;
        chk("b2b_second_rd", {21'd0, mem_rd, mem_addr}, {21'd0, 1'b1, 10'd6});
        repeat (2) step();
        chk("b2b_second_wdata", mem_wdata, 32'h2222F00D);
        repeat (2) step();
        chk("b2b_ram5", ram[5], 32'hDEAD1111);
        chk("b2b_ram6", ram[6], 32'h2222F00D);
        chk("b2b_writes", wr_count - wr0, 32'd2);

        mid_reset(10'd7, 1);
        mid_reset(10'd8, 2);

        // Randomized stores over 16 words against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            preload(10'(i), model[i]);
        end
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  w;
            bit          hi, mis;
            logic [15:0] wd;
            w   = 4'($urandom_range(0, 15));
            hi  = 1'($urandom);
            mis = ($urandom_range(0, 7) == 0);
            wd  = 16'($urandom);
            if (!mis) model[w] = ref_store(model[w], hi, wd);
            do_req({6'd0, w, hi, mis}, wd, model[w], mis);
        end

        chk("no_overlap", overlap_count, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sh_store_rmw_unit.md
Name: sh_store_rmw_unit

Overview:
- Store-side counterpart of the halfword-unsigned load path.
- Accepts a store-halfword (SH) request from the MEM stage: a byte address plus a 16-bit source value.
- Performs a read-modify-write on the single-port, word-wide data memory, which has no byte enables.
- Places the halfword in the correct lane of the 32-bit word and leaves the other lane untouched.
- Sits between the MEM-stage control and the data RAM, and obeys the same ClockEnable/Tick stepping as the pipeline registers.

Parameters:
- AddrBits, 10, word-address width of the data memory; the byte address is AddrBits+2 bits.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ClockEnable  input  1  global enable; state advances only when ClockEnable&Tick=1 (an "advance edge").
- Tick  input  1  single-step/tick qualifier.
- req_valid  input  1  SH request present.
- req_ready  output  1  unit can accept a request (combinational, state==IDLE).
- req_addr  input  AddrBits+2  byte address of the halfword.
- req_wdata  input  16  halfword to store (rs2[15:0]).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-advance-cycle pulse: store committed.
- misaligned  output  1  one-advance-cycle pulse: req_addr[0]=1, request dropped.
- mem_addr  output  AddrBits  word address to RAM (req_addr[AddrBits+1:2], latched).
- mem_rd  output  1  RAM read strobe.
- mem_rdata  input  32  RAM read data, valid one advance edge after mem_rd is sampled.
- mem_wr  output  1  RAM write strobe.
- mem_wdata  output  32  merged word to write.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all registered outputs (done, misaligned, mem_rd, mem_wr, mem_addr, mem_wdata) and internal latches = 0.
  - req_ready=1, busy=0.
- Non-advance cycles (ClockEnable&Tick=0): state, latches and all outputs hold; no new acceptance.
  - RAM samples its strobes with the same qualifier, so held strobes never repeat an access.
- Acceptance: on an advance edge with state==IDLE and req_valid=1, the unit latches req_addr and req_wdata.
- FSM states: IDLE, ERR, RD, CAP, WR, DONE. Transitions on advance edges only:
  - IDLE: req_valid & req_addr[0]=1 -> ERR; req_valid & req_addr[0]=0 -> RD; otherwise stay.
  - ERR: misaligned=1; no RAM strobe ever issued -> IDLE.
  - RD: mem_rd=1, mem_addr=latched word address -> CAP.
  - CAP: mem_rdata captured into the read buffer; mem_rd=0 -> WR.
  - WR: mem_wr=1, mem_addr unchanged, mem_wdata=merged word -> DONE.
  - DONE: done=1 -> IDLE.
- Merge rule (little-endian):
  - addr[1]=0: mem_wdata = {rbuf[31:16], wdata[15:0]}.
  - addr[1]=1: mem_wdata = {wdata[15:0], rbuf[15:0]}.
- Latency and throughput:
  - Acceptance edge to done=1 takes 4 advance edges.
  - Exactly one read and one write per aligned request.
  - Throughput: one request per 5 advance cycles; req_ready=0 in DONE, so back-to-back requests wait one cycle in IDLE.
- Misaligned handling: misaligned is 1 advance cycle after acceptance; done is never asserted for that request.
- Request inputs are ignored outside IDLE; changes to req_* after acceptance have no effect.
- Reset mid-operation:
  - Asserted in RD or CAP: no write occurs; memory keeps its old value.
  - Asserted in WR before the advance edge: write is aborted.
  - In all cases the unit returns to IDLE immediately.
- Strobes: mem_rd and mem_wr are never high together; both are 0 in IDLE, ERR and DONE.

Test Plan:
- Low-half store: RAM[5]=0xDEADBEEF; req_addr=0x014, req_wdata=0x1234 -> mem_rd in RD, mem_wr with mem_wdata=0xDEAD1234 at word 5, done 4 advance edges after acceptance; RAM[5]=0xDEAD1234.
- High-half store: RAM[5]=0xDEADBEEF; req_addr=0x016, req_wdata=0xA5A5 -> mem_wdata=0xA5A5BEEF, done pulse 1 cycle wide.
- Misaligned: req_addr=0x015 -> misaligned=1 for one advance cycle, mem_rd=mem_wr=0 throughout, done never asserted, RAM unchanged.
- Stall: hold ClockEnable=0 for 3 cycles while in CAP -> state, mem_addr and strobes hold; result and done timing otherwise identical; exactly one write observed.
- Back-to-back requests: req_valid held high with two requests to words 5 and 6 -> second accepted only after DONE->IDLE; both writes correct and never overlapping.
- Reset in CAP: assert Reset -> busy=0 and req_ready=1 immediately, no mem_wr, RAM word unchanged; a subsequent request completes normally.
